// File: rtl/bitbakery_serial_rx_frame.sv
// Receiver for the BitBakery 133-byte 8E1 game-state frame.
// A bit-level FSM turns the serial line into byte events; a frame-level FSM
// assembles those bytes into shadow buffers and publishes them to the
// outputs only after the whole frame (start, payload, end marker) is good.
module bitbakery_serial_rx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         entrada_serial,
    output logic [7:0]   D0,
    output logic [7:0]   D1,
    output logic [7:0]   D2,
    output logic [511:0] map_obstacles,
    output logic [511:0] map_objectives,
    output logic         frame_valid,
    output logic         frame_error,
    output logic         busy,
    output logic [3:0]   db_estado
);

    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] START_BYTE = 8'hFF;
    localparam logic [7:0] END_BYTE   = 8'hFE;
    localparam logic [7:0] LAST_IDX   = 8'd131;

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_PARITY,
        B_STOP
    } bit_state_t;

    typedef enum logic [1:0] {
        F_WAIT_START,
        F_RECV,
        F_CHECK_END
    } frame_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic sync_meta;
    logic rx;

    // Two-flop synchronizer; the line idles high, so reset loads ones.
    always_ff @(posedge clock) begin
        // NOTE: sequential state always uses <=, so every flop samples the
        // pre-edge value of its neighbours and the order of statements is irrelevant.
        if (reset) begin
            sync_meta <= 1'b1;
            rx        <= 1'b1;
        end else begin
            sync_meta <= entrada_serial;
            rx        <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Bit-level FSM
    // ------------------------------------------------------------------
    bit_state_t       bit_state;
    bit_state_t       bit_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       data_idx;
    logic [7:0]       byte_data;
    logic             par_err;
    logic             sample;
    logic             start_edge;
    logic             byte_done;
    logic             byte_err;

    // Bit FSM next state and the mid-bit sample strobe.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        bit_next   = bit_state;
        sample     = 1'b0;
        start_edge = 1'b0;
        case (bit_state)
            B_IDLE: begin
                if (!rx) begin
                    bit_next   = B_START;
                    start_edge = 1'b1;
                end
            end
            B_START: begin
                if (bit_cnt == HALF_LAST) begin
                    sample   = 1'b1;
                    bit_next = rx ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    sample = 1'b1;
                    if (data_idx == 3'd7) begin
                        bit_next = B_PARITY;
                    end
                end
            end
            B_PARITY: begin
                if (bit_cnt == BIT_LAST) begin
                    sample   = 1'b1;
                    bit_next = B_STOP;
                end
            end
            B_STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    sample   = 1'b1;
                    bit_next = B_IDLE;
                end
            end
            default: bit_next = B_IDLE;
        endcase
    end

    // Bit FSM state, bit timer, data capture and one-cycle byte events.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_state <= B_IDLE;
            bit_cnt   <= '0;
            data_idx  <= '0;
            byte_data <= '0;
            par_err   <= 1'b0;
            byte_done <= 1'b0;
            byte_err  <= 1'b0;
        end else begin
            bit_state <= bit_next;
            byte_done <= 1'b0;
            byte_err  <= 1'b0;
            if (bit_state == B_IDLE || sample) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (sample) begin
                case (bit_state)
                    B_START:  data_idx <= '0;
                    B_DATA: begin
                        byte_data[data_idx] <= rx;
                        data_idx            <= data_idx + 1'b1;
                    end
                    B_PARITY: par_err <= (^byte_data) ^ rx;
                    B_STOP: begin
                        byte_done <= rx & ~par_err;
                        byte_err  <= ~rx | par_err;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-level FSM
    // ------------------------------------------------------------------
    frame_state_t      frame_state;
    frame_state_t      frame_next;
    logic [7:0]        byte_idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout;
    logic              store;
    logic              commit;
    logic              abort;
    logic [7:0]        sh_d0;
    logic [7:0]        sh_d1;
    logic [7:0]        sh_d2;
    logic [511:0]      sh_obs;
    logic [511:0]      sh_obj;
    logic [5:0]        obs_slot;
    logic [5:0]        obj_slot;
    logic [8:0]        obs_off;
    logic [8:0]        obj_off;

    assign timeout  = (idle_cnt == IDLE_LIMIT);
    assign obs_slot = 6'(byte_idx - 8'd4);
    assign obj_slot = 6'(byte_idx - 8'd68);
    assign obs_off  = {obs_slot, 3'b000};
    assign obj_off  = {obj_slot, 3'b000};
    assign busy      = (frame_state != F_WAIT_START);
    assign db_estado = {2'b00, frame_state};

    // Frame FSM next state plus store / commit / abort decisions.
    always_comb begin
        frame_next = frame_state;
        store      = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        case (frame_state)
            F_WAIT_START: begin
                if (byte_done && byte_data == START_BYTE) begin
                    frame_next = F_RECV;
                end
            end
            F_RECV: begin
                if (byte_err || timeout) begin
                    abort      = 1'b1;
                    frame_next = F_WAIT_START;
                end else if (byte_done) begin
                    store = 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        frame_next = F_CHECK_END;
                    end
                end
            end
            F_CHECK_END: begin
                if (byte_err || timeout) begin
                    abort      = 1'b1;
                    frame_next = F_WAIT_START;
                end else if (byte_done) begin
                    frame_next = F_WAIT_START;
                    if (byte_data == END_BYTE) begin
                        commit = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            default: frame_next = F_WAIT_START;
        endcase
    end

    // Frame state, byte index, shadow buffers and atomic publish of outputs.
    always_ff @(posedge clock) begin
        // NOTE: the shadow buffers are ordinary flops rather than a RAM, so
        // they take the synchronous reset like the rest of the state.
        if (reset) begin
            frame_state    <= F_WAIT_START;
            byte_idx       <= '0;
            sh_d0          <= '0;
            sh_d1          <= '0;
            sh_d2          <= '0;
            sh_obs         <= '0;
            sh_obj         <= '0;
            D0             <= '0;
            D1             <= '0;
            D2             <= '0;
            map_obstacles  <= '0;
            map_objectives <= '0;
            frame_valid    <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            frame_state <= frame_next;
            frame_valid <= commit;
            frame_error <= abort;
            if (frame_state == F_WAIT_START && frame_next == F_RECV) begin
                byte_idx <= 8'd1;
            end else if (store) begin
                byte_idx <= byte_idx + 1'b1;
            end
            if (store) begin
                if (byte_idx == 8'd1) begin
                    sh_d0 <= byte_data;
                end else if (byte_idx == 8'd2) begin
                    sh_d1 <= byte_data;
                end else if (byte_idx == 8'd3) begin
                    sh_d2 <= byte_data;
                end else if (byte_idx < 8'd68) begin
                    sh_obs[obs_off +: 8] <= byte_data;
                end else begin
                    sh_obj[obj_off +: 8] <= byte_data;
                end
            end
            if (commit) begin
                D0             <= sh_d0;
                D1             <= sh_d1;
                D2             <= sh_d2;
                map_obstacles  <= sh_obs;
                map_objectives <= sh_obj;
            end
        end
    end

    // Inter-byte idle timer: counts line-idle cycles inside a frame only.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (frame_state == F_WAIT_START || start_edge) begin
            idle_cnt <= '0;
        end else if (bit_state == B_IDLE && !timeout) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bitbakery_serial_rx_frame.sv
// Self-checking bench for bitbakery_serial_rx_frame: directed frames from the
// test plan plus randomized frames, compared against a byte-level frame model.
module tb_bitbakery_serial_rx_frame;

    localparam int CPB = 8;
    localparam int TOB = 20;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         entrada_serial = 1'b1;
    logic [7:0]   D0;
    logic [7:0]   D1;
    logic [7:0]   D2;
    logic [511:0] map_obstacles;
    logic [511:0] map_objectives;
    logic         frame_valid;
    logic         frame_error;
    logic         busy;
    logic [3:0]   db_estado;

    bitbakery_serial_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .entrada_serial(entrada_serial),
        .D0            (D0),
        .D1            (D1),
        .D2            (D2),
        .map_obstacles (map_obstacles),
        .map_objectives(map_objectives),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .busy          (busy),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- observed pulse bookkeeping ----------------
    int n_valid      = 0;
    int n_error      = 0;
    int n_events     = 0;
    int valid_cyc    = 0;
    int error_cyc    = 0;
    int stop_end_cyc = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (frame_valid) begin
                n_valid++;
                valid_cyc = cyc;
            end
            if (frame_error) begin
                n_error++;
                error_cyc = cyc;
            end
            if (frame_valid || frame_error) begin
                check("pulse_exclusive", frame_valid & frame_error, 1'b0);
            end
            if (dut.byte_done || dut.byte_err) n_events++;
        end
    end

    // ---------------- frame-level reference model ----------------
    logic [7:0]   m_buf[$];
    bit           m_in = 1'b0;
    int           m_valid = 0;
    int           m_err = 0;
    logic [7:0]   e_d0 = '0;
    logic [7:0]   e_d1 = '0;
    logic [7:0]   e_d2 = '0;
    logic [511:0] e_obs = '0;
    logic [511:0] e_obj = '0;

    task automatic model_byte(input logic [7:0] b, input bit err);
        if (!m_in) begin
            if (!err && b == 8'hFF) begin
                m_in = 1'b1;
                m_buf.delete();
            end
        end else if (err) begin
            m_in = 1'b0;
            m_err++;
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == 132) begin
                m_in = 1'b0;
                if (b == 8'hFE) begin
                    m_valid++;
                    e_d0 = m_buf[0];
                    e_d1 = m_buf[1];
                    e_d2 = m_buf[2];
                    for (int k = 0; k < 64; k++) begin
                        e_obs[8*k +: 8] = m_buf[3 + k];
                        e_obj[8*k +: 8] = m_buf[67 + k];
                    end
                end else begin
                    m_err++;
                end
            end
        end
    endtask

    task automatic model_timeout();
        if (m_in) begin
            m_in = 1'b0;
            m_err++;
        end
    endtask

    task automatic model_reset();
        m_in  = 1'b0;
        e_d0  = '0;
        e_d1  = '0;
        e_d2  = '0;
        e_obs = '0;
        e_obj = '0;
    endtask

    // ---------------- stimulus helpers ----------------
    logic [7:0] frm [133];

    function automatic void build_test1();
        frm[0] = 8'hFF;
        frm[1] = 8'h12;
        frm[2] = 8'h34;
        frm[3] = 8'h56;
        for (int k = 0; k < 64; k++) begin
            frm[4 + k]  = 8'(k);
            frm[68 + k] = 8'hFF - 8'(k);
        end
        frm[132] = 8'hFE;
    endfunction

    function automatic void build_random();
        frm[0] = 8'hFF;
        for (int i = 1; i < 132; i++) frm[i] = 8'($urandom);
        frm[132] = 8'hFE;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input int gap_bits);
        logic [10:0] line_bits;
        line_bits = {1'b1, (^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            entrada_serial = line_bits[i];
            repeat (CPB) @(negedge clock);
        end
        stop_end_cyc = cyc;
        model_byte(b, bad_par);
        if (gap_bits > 0) repeat (gap_bits * CPB) @(negedge clock);
    endtask

    task automatic send_frame(input int first, input int last, input int err_idx, input bit rand_gap);
        int gap;
        for (int i = first; i <= last; i++) begin
            gap = (rand_gap && $urandom_range(0, 3) == 0) ? 1 : 0;
            send_byte(frm[i], i == err_idx, gap);
        end
    endtask

    task automatic idle_bits(input int n);
        entrada_serial = 1'b1;
        repeat (n * CPB) @(negedge clock);
        if (n > TOB) model_timeout();
    endtask

    task automatic check_state(input string p);
        check({p, ".D0"}, D0, e_d0);
        check({p, ".D1"}, D1, e_d1);
        check({p, ".D2"}, D2, e_d2);
        check({p, ".obstacles"}, map_obstacles, e_obs);
        check({p, ".objectives"}, map_objectives, e_obj);
        check({p, ".valid_count"}, n_valid, m_valid);
        check({p, ".error_count"}, n_error, m_err);
        check({p, ".busy"}, busy, m_in);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int d;
        int ev0;
        int err0;

        repeat (4) @(negedge clock);
        check("reset.D0", D0, 8'h00);
        check("reset.D1", D1, 8'h00);
        check("reset.D2", D2, 8'h00);
        check("reset.obstacles", map_obstacles, '0);
        check("reset.objectives", map_objectives, '0);
        check("reset.frame_valid", frame_valid, 1'b0);
        check("reset.frame_error", frame_error, 1'b0);
        check("reset.busy", busy, 1'b0);
        check("reset.db_estado", db_estado, 4'h0);
        reset = 1'b0;
        model_reset();
        idle_bits(2);

        // 1: clean frame
        build_test1();
        send_frame(0, 132, -1, 1'b0);
        idle_bits(3);
        check_state("t1");
        check("t1.D0_const", D0, 8'h12);
        check("t1.D1_const", D1, 8'h34);
        check("t1.D2_const", D2, 8'h56);
        check("t1.obs_first", map_obstacles[7:0], 8'h00);
        check("t1.obs_last", map_obstacles[511:504], 8'h3F);
        check("t1.obj_first", map_objectives[7:0], 8'hFF);
        d = valid_cyc - stop_end_cyc;
        check("t1.valid_latency_in_window", (d >= -4 && d <= 4), 1'b1);

        // 2: garbage before the frame is ignored silently
        send_byte(8'h00, 1'b0, 1);
        send_byte(8'hFE, 1'b0, 1);
        send_byte(8'h55, 1'b0, 1);
        send_frame(0, 132, -1, 1'b0);
        idle_bits(3);
        check_state("t2");

        // 5: inter-byte timeout, then a clean frame
        err0 = n_error;
        send_frame(0, 10, -1, 1'b0);
        entrada_serial = 1'b1;
        repeat (10 * CPB) @(negedge clock);
        check("t5.busy_before_timeout", busy, 1'b1);
        check("t5.no_early_error", n_error, err0);
        repeat (11 * CPB) @(negedge clock);
        model_timeout();
        d = error_cyc - stop_end_cyc;
        check("t5.timeout_delay_in_window", (d >= TOB * CPB - CPB && d <= TOB * CPB + CPB), 1'b1);
        check_state("t5a");
        send_frame(0, 132, -1, 1'b0);
        idle_bits(3);
        check_state("t5b");

        // 3: parity error on byte 70 aborts, outputs keep the previous frame
        build_random();
        send_frame(0, 69, -1, 1'b0);
        check("t3.busy_mid_frame", busy, 1'b1);
        send_frame(70, 70, 70, 1'b0);
        idle_bits(1);
        d = error_cyc - stop_end_cyc;
        check("t3.error_latency_in_window", (d >= -4 && d <= 4), 1'b1);
        idle_bits(2);
        check_state("t3");
        check("t3.D0_kept", D0, 8'h12);

        // 4: bad end marker
        build_test1();
        frm[1]   = 8'hAA;
        frm[4]   = 8'h99;
        frm[132] = 8'hFD;
        send_frame(0, 132, -1, 1'b0);
        idle_bits(3);
        check_state("t4");
        check("t4.D0_kept", D0, 8'h12);

        // 6a: three-cycle low glitch produces no byte event
        ev0 = n_events;
        entrada_serial = 1'b0;
        repeat (3) @(negedge clock);
        idle_bits(3);
        check("t6.glitch_events", n_events - ev0, 0);
        check("t6.glitch_state", db_estado, 4'h0);

        // 6b: reset in the middle of a frame
        build_test1();
        send_frame(0, 5, -1, 1'b0);
        check("t6.busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t6.rst.D0", D0, 8'h00);
        check("t6.rst.D1", D1, 8'h00);
        check("t6.rst.D2", D2, 8'h00);
        check("t6.rst.obstacles", map_obstacles, '0);
        check("t6.rst.objectives", map_objectives, '0);
        check("t6.rst.busy", busy, 1'b0);
        check("t6.rst.db_estado", db_estado, 4'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        idle_bits(2);

        // randomized frames: garbage prefix, random gaps, random end byte,
        // second pass truncated at a random parity error
        for (int it = 0; it < 2; it++) begin
            int n_garbage;
            int err_idx;
            int last;
            n_garbage = $urandom_range(0, 2);
            for (int g = 0; g < n_garbage; g++) send_byte(8'($urandom), 1'b0, 1);
            build_random();
            if ($urandom_range(0, 3) == 0) frm[132] = 8'($urandom);
            if (it == 0) begin
                err_idx = -1;
                last    = 132;
            end else begin
                err_idx = $urandom_range(5, 60);
                last    = err_idx;
            end
            send_frame(0, last, err_idx, 1'b1);
            idle_bits(22);
            check_state($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
